// File: rtl/fb_fill.sv
// fb_fill: AXI4 write-burst master that paints a rectangle of the framebuffer with one RGB colour.
// Optional feature: define FB_FILL_ABORT_EN to add the ABORT input (finish current burst, then stop).

module fb_fill #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int STRIDE             = 2560,
  parameter int MAXBURST           = 16
) (
  input  logic                              ACLK,
  input  logic                              ARST,
  input  logic                              START,
  input  logic [29:0]                       DSTADDR,
  input  logic [8:0]                        WIDTH,
  input  logic [9:0]                        HEIGHT,
  input  logic [23:0]                       COLOR,
`ifdef FB_FILL_ABORT_EN
  input  logic                              ABORT,
`endif
  output logic                              BUSY,
  output logic                              DONE,
  output logic                              ERR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic [2:0]                        M_AXI_AWSIZE,
  output logic [1:0]                        M_AXI_AWBURST,
  output logic [3:0]                        M_AXI_AWCACHE,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWLOCK,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic                              M_AXI_BREADY,
  input  logic                              M_AXI_BVALID,
  input  logic [1:0]                        M_AXI_BRESP
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_FIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, lineBase_q, lineBase_d;
  logic [8:0]  width_q, width_d, rem_q, rem_d, remLeft;
  logic [9:0]  height_q, height_d, line_q, line_d;
  logic [23:0] color_q, color_d;
  logic [4:0]  len_q, len_d, beat_q, beat_d, lenCalc;
  logic        err_q, err_d, abortNow;
  logic [9:0]  pageBeats, lenWide;

`ifdef FB_FILL_ABORT_EN
  logic abort_q, abort_d;
  assign abortNow = abort_q | ABORT;
  assign abort_d  = (state_q != S_IDLE) & abortNow;
`else
  assign abortNow = 1'b0;
`endif

  assign remLeft = rem_q - 9'(len_q);

  // Burst length is capped by MAXBURST, the words left on the line and the room before the next 4 KB page.
  always_comb begin
    pageBeats = 10'((13'h1000 - {1'b0, addr_q[11:0]}) >> 3);
    lenWide   = {1'b0, rem_q};
    if (pageBeats < lenWide) lenWide = pageBeats;
    if (lenWide > 10'(MAXBURST)) lenWide = 10'(MAXBURST);
    lenCalc = 5'(lenWide);
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      lineBase_q <= '0;
      width_q    <= '0;
      rem_q      <= '0;
      height_q   <= '0;
      line_q     <= '0;
      color_q    <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
`ifdef FB_FILL_ABORT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lineBase_q <= lineBase_d;
      width_q    <= width_d;
      rem_q      <= rem_d;
      height_q   <= height_d;
      line_q     <= line_d;
      color_q    <= color_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
`ifdef FB_FILL_ABORT_EN
      abort_q    <= abort_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lineBase_d = lineBase_q;
    width_d    = width_q;
    rem_d      = rem_q;
    height_d   = height_q;
    line_d     = line_q;
    color_d    = color_q;
    len_d      = len_q;
    beat_d     = beat_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: if (START) begin
        addr_d     = {DSTADDR, 2'b00};
        lineBase_d = {DSTADDR, 2'b00};
        width_d    = WIDTH;
        rem_d      = WIDTH;
        height_d   = HEIGHT;
        line_d     = '0;
        color_d    = COLOR;
        err_d      = 1'b0;
        state_d    = S_CALC;
      end
      S_CALC: begin
        if (width_q == 9'd0 || height_q == 10'd0) begin
          state_d = S_FIN;
        end else begin
          len_d   = lenCalc;
          state_d = S_AW;
        end
      end
      S_AW: if (M_AXI_AWREADY) begin
        beat_d  = '0;
        state_d = S_W;
      end
      S_W: if (M_AXI_WREADY) begin
        if (beat_q == len_q - 5'd1) state_d = S_B;
        else beat_d = beat_q + 5'd1;
      end
      S_B: if (M_AXI_BVALID) begin
        if (M_AXI_BRESP != 2'b00) err_d = 1'b1;
        addr_d  = addr_q + {24'd0, len_q, 3'd0};
        rem_d   = remLeft;
        state_d = S_CALC;
        // End of a line: either the rectangle is finished or we rewind to the next line's start.
        if (remLeft == 9'd0) begin
          line_d = line_q + 10'd1;
          if (line_d == height_q) begin
            state_d = S_FIN;
          end else begin
            lineBase_d = lineBase_q + 32'(STRIDE);
            addr_d     = lineBase_d;
            rem_d      = width_q;
          end
        end
        if (abortNow) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY          = (state_q != S_IDLE);
    DONE          = (state_q == S_FIN);
    ERR           = err_q;
    M_AXI_AWVALID = (state_q == S_AW);
    M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'(addr_q);
    M_AXI_AWLEN   = (state_q == S_AW) ? {3'b000, len_q - 5'd1} : 8'h00;
    M_AXI_AWSIZE  = 3'd3;
    M_AXI_AWBURST = 2'b01;
    M_AXI_AWCACHE = 4'b0011;
    M_AXI_AWPROT  = 3'b000;
    M_AXI_AWLOCK  = 1'b0;
    M_AXI_WVALID  = (state_q == S_W);
    M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'({8'h00, color_q, 8'h00, color_q});
    M_AXI_WSTRB   = (state_q == S_W) ? '1 : '0;
    M_AXI_WLAST   = (state_q == S_W) && (beat_q == len_q - 5'd1);
    M_AXI_BREADY  = (state_q == S_B);
  end

endmodule

// File: tb/tb_fb_fill.sv
// tb_fb_fill: scoreboard bench for fb_fill; expected AW bursts are queued, a slave/monitor process checks them.
// Build with FB_FILL_ABORT_EN defined to also exercise the ABORT input.

module tb_fb_fill;

  logic        ACLK, ARST, START;
  logic [29:0] DSTADDR;
  logic [8:0]  WIDTH;
  logic [9:0]  HEIGHT;
  logic [23:0] COLOR;
`ifdef FB_FILL_ABORT_EN
  logic        ABORT;
`endif
  logic        BUSY, DONE, ERR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_AWLOCK;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE, M_AXI_AWPROT;
  logic [1:0]  M_AXI_AWBURST, M_AXI_BRESP;
  logic [3:0]  M_AXI_AWCACHE;
  logic        M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_BREADY, M_AXI_BVALID;

  fb_fill dut (
    .ACLK(ACLK), .ARST(ARST), .START(START), .DSTADDR(DSTADDR), .WIDTH(WIDTH),
    .HEIGHT(HEIGHT), .COLOR(COLOR),
`ifdef FB_FILL_ABORT_EN
    .ABORT(ABORT),
`endif
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BRESP(M_AXI_BRESP)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] awlen; } awExp_t;
  awExp_t expAw[$];

  int checks = 0, errors = 0, cyc = 0;
  int doneCount = 0, doneCyc = 0, wBeats = 0, awValidCount = 0, bRaised = 0;
  int doneBase = 0, beatBase = 0, startCyc = 0;
  int errTarget = -1, flushReq = 0;
  logic stallMode = 1'b0;
  logic [23:0] expColor = '0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic pushAw(input logic [31:0] addr, input logic [7:0] awlen);
    expAw.push_back('{addr: addr, awlen: awlen});
  endtask

  // Slave model plus monitor: drives READY/BVALID at the falling edge, then samples handshakes that the next rising edge will complete.
  initial begin
    int bPending = 0, curLen = 0, beatCnt = 0, flushSeen = 0;
    logic bHs = 1'b0, awOpen = 1'b0, awHeld = 1'b0, wHeld = 1'b0, heldWlast = 1'b0;
    logic [39:0] heldAw = '0;
    logic [63:0] heldWdata = '0;
    awExp_t e;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    forever begin
      @(negedge ACLK);
      if (flushSeen != flushReq) begin
        flushSeen = flushReq;
        expAw.delete();
        bPending = 0; curLen = 0; beatCnt = 0;
        bHs = 1'b0; awOpen = 1'b0; awHeld = 1'b0; wHeld = 1'b0;
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
      end
      if (bHs) begin
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
        bHs = 1'b0;
      end
      M_AXI_AWREADY = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXI_WREADY  = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!M_AXI_BVALID && bPending > 0 && (!stallMode || $urandom_range(0, 2) == 0)) begin
        bPending--;
        bRaised++;
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = (bRaised == errTarget) ? 2'b10 : 2'b00;
      end
      #1;
      if (!ARST) begin
        if (DONE) begin
          doneCount++;
          doneCyc = cyc;
        end
        if (M_AXI_AWVALID) awValidCount++;
        if (awHeld) begin
          checkOutput("aw_hold_valid", 64'(M_AXI_AWVALID), 64'd1);
          checkOutput("aw_hold_payload", 64'({M_AXI_AWADDR, M_AXI_AWLEN}), 64'(heldAw));
        end
        awHeld = M_AXI_AWVALID && !M_AXI_AWREADY;
        heldAw = {M_AXI_AWADDR, M_AXI_AWLEN};
        if (wHeld) begin
          checkOutput("w_hold_valid", 64'(M_AXI_WVALID), 64'd1);
          checkOutput("w_hold_data", M_AXI_WDATA, heldWdata);
          checkOutput("w_hold_last", 64'(M_AXI_WLAST), 64'(heldWlast));
        end
        wHeld = M_AXI_WVALID && !M_AXI_WREADY;
        heldWdata = M_AXI_WDATA;
        heldWlast = M_AXI_WLAST;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          checkOutput("aw_expected", 64'(expAw.size() != 0), 64'd1);
          if (expAw.size() != 0) begin
            e = expAw.pop_front();
            checkOutput("awaddr", 64'(M_AXI_AWADDR), 64'(e.addr));
            checkOutput("awlen", 64'(M_AXI_AWLEN), 64'(e.awlen));
          end
          curLen  = int'(M_AXI_AWLEN) + 1;
          beatCnt = 0;
          awOpen  = 1'b1;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          checkOutput("w_after_aw", 64'(awOpen), 64'd1);
          checkOutput("wdata", M_AXI_WDATA, {8'h00, expColor, 8'h00, expColor});
          checkOutput("wstrb", 64'(M_AXI_WSTRB), 64'hFF);
          checkOutput("wlast", 64'(M_AXI_WLAST), 64'(beatCnt == curLen - 1));
          wBeats++;
          beatCnt++;
          if (beatCnt >= curLen) begin
            bPending++;
            awOpen = 1'b0;
          end
        end
        if (M_AXI_BVALID && M_AXI_BREADY) bHs = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] byteAddr, input logic [8:0] w,
                               input logic [9:0] h, input logic [23:0] color);
    @(negedge ACLK);
    doneBase = doneCount;
    beatBase = wBeats;
    expColor = color;
    DSTADDR  = byteAddr[31:2];
    WIDTH    = w;
    HEIGHT   = h;
    COLOR    = color;
    START    = 1'b1;
    startCyc = cyc;
    @(negedge ACLK);
    START = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget, input int expBeats, input logic expErr);
    for (int i = 0; i < budget && doneCount == doneBase; i++) begin
      @(negedge ACLK);
      #2;
    end
    repeat (3) @(negedge ACLK);
    #2;
    checkOutput({name, "_done_pulses"}, 64'(doneCount - doneBase), 64'd1);
    checkOutput({name, "_beats"}, 64'(wBeats - beatBase), 64'(expBeats));
    checkOutput({name, "_aw_left"}, 64'(expAw.size()), 64'd0);
    checkOutput({name, "_err"}, 64'(ERR), 64'(expErr));
    checkOutput({name, "_busy"}, 64'(BUSY), 64'd0);
  endtask

  task automatic waitForW(input string name);
    for (int i = 0; i < 200 && !M_AXI_WVALID; i++) begin
      @(negedge ACLK);
      #2;
    end
    checkOutput({name, "_reached_w"}, 64'(M_AXI_WVALID), 64'd1);
  endtask

  initial begin
    int awBase;
    ARST = 1'b1; START = 1'b0; DSTADDR = '0; WIDTH = '0; HEIGHT = '0; COLOR = '0;
`ifdef FB_FILL_ABORT_EN
    ABORT = 1'b0;
`endif
    repeat (3) @(negedge ACLK);
    #2;
    checkOutput("reset_outputs", 64'({BUSY, DONE, ERR, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_WLAST}), 64'd0);
    @(negedge ACLK);
    ARST = 1'b0;

    $display("[TB] full-width fill, two lines");
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 20; b++)
        pushAw(32'h1000_0000 + 32'(l * 32'hA00) + 32'(b * 32'h80), 8'd15);
    applyStimulus(32'h1000_0000, 9'd320, 10'd2, 24'h123456);
    waitDone("t1", 3000, 640, 1'b0);

    $display("[TB] 4 KB boundary split");
    pushAw(32'h1000_0FC0, 8'd7);
    pushAw(32'h1000_1000, 8'd11);
    applyStimulus(32'h1000_0FC0, 9'd20, 10'd1, 24'hABCDEF);
    waitDone("t2", 500, 20, 1'b0);

    $display("[TB] random slave stalls");
    stallMode = 1'b1;
    pushAw(32'h1000_0000, 8'd15); pushAw(32'h1000_0080, 8'd3);
    pushAw(32'h1000_0A00, 8'd15); pushAw(32'h1000_0A80, 8'd3);
    pushAw(32'h1000_1400, 8'd15); pushAw(32'h1000_1480, 8'd3);
    applyStimulus(32'h1000_0000, 9'd20, 10'd3, 24'h00FF00);
    waitDone("t3", 3000, 60, 1'b0);
    stallMode = 1'b0;

    $display("[TB] error response");
    errTarget = bRaised + 1;
    pushAw(32'h1000_0000, 8'd3);
    pushAw(32'h1000_0A00, 8'd3);
    applyStimulus(32'h1000_0000, 9'd4, 10'd2, 24'hFF0000);
    waitDone("t4", 500, 8, 1'b1);
    errTarget = -1;

    $display("[TB] empty rectangle, START while busy");
    awBase = awValidCount;
    applyStimulus(32'h1000_0000, 9'd0, 10'd5, 24'h0000FF);
    #2;
    checkOutput("t5_err_cleared", 64'(ERR), 64'd0);
    checkOutput("t5_busy", 64'(BUSY), 64'd1);
    START = 1'b1;
    @(negedge ACLK);
    START = 1'b0;
    repeat (6) @(negedge ACLK);
    #2;
    checkOutput("t5_done_pulses", 64'(doneCount - doneBase), 64'd1);
    checkOutput("t5_done_latency", 64'(doneCyc - startCyc), 64'd2);
    checkOutput("t5_no_aw", 64'(awValidCount - awBase), 64'd0);
    checkOutput("t5_idle", 64'(BUSY), 64'd0);

    $display("[TB] reset during write data");
    for (int b = 0; b < 20; b++) pushAw(32'h1000_0000 + 32'(b * 32'h80), 8'd15);
    applyStimulus(32'h1000_0000, 9'd320, 10'd1, 24'h5A5A5A);
    waitForW("t6");
    repeat (3) @(negedge ACLK);
    ARST = 1'b1;
    flushReq++;
    @(negedge ACLK);
    #2;
    checkOutput("t6_reset_outputs", 64'({BUSY, DONE, ERR, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_WLAST}), 64'd0);
    ARST = 1'b0;
    awBase = awValidCount;
    repeat (5) @(negedge ACLK);
    #2;
    checkOutput("t6_stays_idle", 64'({BUSY, M_AXI_WVALID}), 64'd0);
    checkOutput("t6_no_aw", 64'(awValidCount - awBase), 64'd0);

`ifdef FB_FILL_ABORT_EN
    $display("[TB] abort mid-burst");
    pushAw(32'h1000_0000, 8'd15);
    applyStimulus(32'h1000_0000, 9'd320, 10'd1, 24'h777777);
    waitForW("t7");
    @(negedge ACLK);
    ABORT = 1'b1;
    @(negedge ACLK);
    ABORT = 1'b0;
    waitDone("t7", 500, 16, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
